// File: rtl/rv32i_pkg.sv
// Shared RV32I constants and types for the write-back stage.
package rv32i_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    // Result source select
    localparam logic [1:0] RES_ALU  = 2'b00;
    localparam logic [1:0] RES_LOAD = 2'b01;
    localparam logic [1:0] RES_PC4  = 2'b10;
    localparam logic [1:0] RES_NONE = 2'b11;

    // Load size/sign encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // MEM/WB pipeline register contents
    typedef struct packed {
        logic              valid;
        logic              reg_write;
        logic [REG_AW-1:0] rd;
        logic [1:0]        result_src;
        logic [2:0]        funct3;
        logic [XLEN-1:0]   alu_result;
        logic [XLEN-1:0]   pc_plus4;
        logic [XLEN-1:0]   read_data;
    } memwb_t;

    // Widen a byte (is_half = 0) or halfword (is_half = 1) to XLEN, signed or unsigned.
    function automatic logic [XLEN-1:0] extend_load(input logic [15:0] v,
                                                     input logic        is_half,
                                                     input logic        sign_ext);
        logic [XLEN-1:0] r;
        if (is_half) begin
            r = {{(XLEN-16){sign_ext & v[15]}}, v};
        end else begin
            r = {{(XLEN-8){sign_ext & v[7]}}, v[7:0]};
        end
        return r;
    endfunction

endpackage

// File: rtl/load_extract.sv
// Combinational load-data extraction: picks the addressed byte/half/word out of
// the aligned memory word, extends it, and flags illegal size or misalignment.
module load_extract
    import rv32i_pkg::*;
(
    input  logic [XLEN-1:0] word,
    input  logic [1:0]      off,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] data,
    output logic            fault
);

    logic [7:0]  byte_sel_s;
    logic [15:0] half_sel_s;

    // Select the addressed byte and halfword lanes.
    always_comb begin
        byte_sel_s = 8'h00;
        case (off)
            2'b00:   byte_sel_s = word[7:0];
            2'b01:   byte_sel_s = word[15:8];
            2'b10:   byte_sel_s = word[23:16];
            2'b11:   byte_sel_s = word[31:24];
            default: byte_sel_s = 8'h00;
        endcase
        if (off[1]) begin
            half_sel_s = word[31:16];
        end else begin
            half_sel_s = word[15:0];
        end
    end

    // Decode size/sign; any illegal encoding or misaligned access yields zero data.
    always_comb begin
        data  = {XLEN{1'b0}};
        fault = 1'b0;
        case (funct3)
            F3_LB:  data = extend_load({8'h00, byte_sel_s}, 1'b0, 1'b1);
            F3_LBU: data = extend_load({8'h00, byte_sel_s}, 1'b0, 1'b0);
            F3_LH: begin
                if (off[0]) begin
                    fault = 1'b1;
                end else begin
                    data = extend_load(half_sel_s, 1'b1, 1'b1);
                end
            end
            F3_LHU: begin
                if (off[0]) begin
                    fault = 1'b1;
                end else begin
                    data = extend_load(half_sel_s, 1'b1, 1'b0);
                end
            end
            F3_LW: begin
                if (off != 2'b00) begin
                    fault = 1'b1;
                end else begin
                    data = word;
                end
            end
            default: fault = 1'b1;
        endcase
    end

endmodule

// File: rtl/reg_writeback.sv
// RV32I write-back stage: MEM/WB register, result select, register-file write
// port, decode bypass outputs and the retired-instruction counter.
module reg_writeback
    import rv32i_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_m,
    input  logic              reg_write_m,
    input  logic [REG_AW-1:0] rd_m,
    input  logic [1:0]        result_src_m,
    input  logic [2:0]        funct3_m,
    input  logic [XLEN-1:0]   alu_result_m,
    input  logic [XLEN-1:0]   pc_plus4_m,
    input  logic [XLEN-1:0]   read_data_m,
    input  logic              stall_w,
    input  logic              flush_w,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [XLEN-1:0]   rf_wdata,
    output logic              fwd_valid_w,
    output logic [REG_AW-1:0] fwd_rd_w,
    output logic [XLEN-1:0]   fwd_data_w,
    output logic              load_fault_w,
    output logic [63:0]       instret
);

    memwb_t          wb_r;
    logic [63:0]     instret_r;
    logic [XLEN-1:0] ext_data_s;
    logic            ext_fault_s;
    logic            load_fault_s;
    logic            we_s;
    logic [XLEN-1:0] wdata_s;

    // MEM/WB register: flush inserts a bubble and beats stall; stall holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_r <= '0;
        end else if (flush_w) begin
            wb_r <= '0;
        end else if (!stall_w) begin
            wb_r <= '{valid:      valid_m,
                      reg_write:  reg_write_m,
                      rd:         rd_m,
                      result_src: result_src_m,
                      funct3:     funct3_m,
                      alu_result: alu_result_m,
                      pc_plus4:   pc_plus4_m,
                      read_data:  read_data_m};
        end else begin
            wb_r <= wb_r;
        end
    end

    load_extract u_load_extract (
        .word   (wb_r.read_data),
        .off    (wb_r.alu_result[1:0]),
        .funct3 (wb_r.funct3),
        .data   (ext_data_s),
        .fault  (ext_fault_s)
    );

    // A fault only counts when a valid load occupies WB.
    always_comb begin
        load_fault_s = 1'b0;
        if (wb_r.valid && (wb_r.result_src == RES_LOAD)) begin
            load_fault_s = ext_fault_s;
        end else begin
            load_fault_s = 1'b0;
        end
    end

    // Result source select; the reserved encoding writes nothing.
    always_comb begin
        wdata_s = {XLEN{1'b0}};
        case (wb_r.result_src)
            RES_ALU:  wdata_s = wb_r.alu_result;
            RES_LOAD: wdata_s = ext_data_s;
            RES_PC4:  wdata_s = wb_r.pc_plus4;
            default:  wdata_s = {XLEN{1'b0}};
        endcase
    end

    // Write enable: never x0, never on a fault or the reserved source.
    always_comb begin
        we_s = 1'b0;
        if (wb_r.valid && wb_r.reg_write && (wb_r.rd != {REG_AW{1'b0}}) &&
            !load_fault_s && (wb_r.result_src != RES_NONE)) begin
            we_s = 1'b1;
        end else begin
            we_s = 1'b0;
        end
    end

    // Retire count: every valid WB instruction that is not stalled, faults included.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instret_r <= 64'd0;
        end else if (wb_r.valid && !stall_w) begin
            instret_r <= instret_r + 64'd1;
        end else begin
            instret_r <= instret_r;
        end
    end

    assign rf_we        = we_s;
    assign rf_waddr     = wb_r.rd;
    assign rf_wdata     = wdata_s;
    assign fwd_valid_w  = we_s;
    assign fwd_rd_w     = wb_r.rd;
    assign fwd_data_w   = wdata_s;
    assign load_fault_w = load_fault_s;
    assign instret      = instret_r;

endmodule

// File: doc/reg_writeback.md
# reg_writeback

Write-back stage of the RV32I pipeline, and the writing end of the register file's write port. It holds the MEM/WB pipeline register and selects the result source. It sign- or zero-extends load data, then drives the register file's write enable, address and data. It also presents the in-flight write-back value to the hazard unit for decode-stage bypass and keeps a 64-bit retired-instruction counter.

## Interface
- XLEN, 32, datapath width
- REG_AW, 5, register address width
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-high reset
- valid_m  in  1  MEM-stage instruction valid
- reg_write_m  in  1  instruction writes rd
- rd_m  in  REG_AW  destination register
- result_src_m  in  2  result select: 00 ALU, 01 load, 10 PC+4, 11 reserved
- funct3_m  in  3  load size/sign: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu
- alu_result_m  in  XLEN  ALU result; bits [1:0] are the load byte offset
- pc_plus4_m  in  XLEN  PC+4 of the instruction
- read_data_m  in  XLEN  raw aligned word from data memory
- stall_w  in  1  hold the MEM/WB register
- flush_w  in  1  insert a bubble into the MEM/WB register
- rf_we  out  1  register file write enable
- rf_waddr  out  REG_AW  register file write address
- rf_wdata  out  XLEN  register file write data
- fwd_valid_w  out  1  a write-back to fwd_rd_w is pending this cycle
- fwd_rd_w  out  REG_AW  equals rf_waddr
- fwd_data_w  out  XLEN  equals rf_wdata
- load_fault_w  out  1  load with an illegal funct3 or misaligned offset reached WB
- instret  out  64  retired-instruction count

## Operation
- **MEM/WB register.** Updates on posedge clk.
  - flush_w: captured valid cleared; flush has priority over stall.
  - else stall_w: register holds its value.
  - else: register captures all *_m inputs.
- **Result select.** Combinational from the registered fields.
  - 00: ALU result.
  - 01: extracted load data.
  - 10: PC+4.
  - 11: zero, with rf_we forced low.
- **Load extraction.** off = registered alu_result[1:0].
  - lb/lbu: byte = word[8*off+7 : 8*off], sign- or zero-extended.
  - lh/lhu: off[0] must be 0; half = word[16*off[1]+15 : 16*off[1]], extended.
  - lw: off must be 00.
  - Illegal funct3, or a misaligned offset: data = 0, rf_we = 0, load_fault_w = 1.
- **rf_we.** valid_w & reg_write_w & (rd_w ≠ 0) & no fault & result_src ≠ 11. x0 is never written.
- **Forwarding outputs.** fwd_valid_w = rf_we; fwd_rd_w and fwd_data_w mirror rf_waddr and rf_wdata.
- **instret.** Increments by 1 on each posedge where valid_w = 1 and stall_w = 0. Faulting instructions still retire. Wraps from 2^64−1 to 0.

## Timing
- Latency: an instruction presented on *_m before posedge N appears on rf_* after N. The register file commits it at posedge N+1.
- The register file reads combinationally and writes on the clock edge. A same-cycle decode read of rf_waddr returns the old value, so the hazard unit must bypass using fwd_*.
- During stall, rf_* outputs hold steady. The register file's rewrite of the same value is idempotent, so it is permitted.
- **Reset.** Asynchronous; the values below hold for as long as rst is high.
  - valid_w = 0, all registered fields = 0.
  - rf_we = 0, rf_waddr = 0, rf_wdata = 0.
  - fwd_valid_w = 0, load_fault_w = 0, instret = 0.
- **Reset mid-operation.** The pending write is dropped, with no partial write.
- stall_w and flush_w together: flush wins and a bubble is inserted.
- load_fault_w is combinational from the registered state. It stays high for every stalled cycle.

## Structure
- Shared package rv32i_pkg:
  - result-source constants RES_ALU, RES_LOAD, RES_PC4;
  - load funct3 constants F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU;
  - XLEN.
- One sub-module, load_extract: purely combinational; inputs word, off and funct3; outputs data and fault.
- The pipeline register, select logic and counter stay in the top level.

## Test plan
- **Reset.** Assert rst mid-cycle with valid_m = 1. Required: rf_we = 0, rf_wdata = 0 and instret = 0 immediately, and after release until the next capture.
- **ALU write.** rd = 5, src = 00, alu = 0x00000020. Required: rf_we = 1, rf_waddr = 5, rf_wdata = 0x20 one cycle later. Repeat with rd = 0: required rf_we = 0.
- **Loads.**
  - read_data = 0x80FF7F01, lb with off = 3: required 0xFFFFFF80.
  - lbu, off = 1: required 0x0000007F.
  - lh, off = 2: required 0xFFFF80FF.
  - lhu, off = 2: required 0x000080FF.
  - lw: required 0x80FF7F01.
- **Fault.** lw with off = 2, and separately funct3 = 011. Required: load_fault_w = 1, rf_we = 0, and instret still increments.
- **Stall and flush.**
  - Stall 3 cycles. Required: rf_* stable and instret unchanged.
  - Assert stall and flush together. Required: fwd_valid_w = 0 the next cycle.
- **PC+4.** src = 10, pc_plus4 = 0x00000104, rd = 1. Required: rf_wdata = 0x104.
- **Sequence.** 10 back-to-back valid instructions. Required: instret = 10.
